// File: rtl/dsp48a1_pkg.sv
// Shared widths, operand-select codes and carry-in source names for the DSP48A1 slice model.
package dsp48a1_pkg;

  localparam int unsigned P_W      = 48;
  localparam int unsigned M_W      = 36;
  localparam int unsigned OPMODE_W = 8;

  localparam int unsigned OPM_CYI_BIT = 5;
  localparam int unsigned OPM_SUB_BIT = 7;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam string CARRYINSEL_OPMODE5 = "OPMODE5";
  localparam string CARRYINSEL_CARRYIN = "CARRYIN";

  // 49-bit post-adder: bit P_W is the carry on add, the borrow on subtract.
  function automatic logic [P_W:0] post_add(input logic sub, input logic [P_W-1:0] z,
                                            input logic [P_W-1:0] x, input logic cyi);
    logic [P_W:0] addend;
    addend = {1'b0, x} + (P_W+1)'(cyi);
    if (sub) begin
      post_add = {1'b0, z} - addend;
    end else begin
      post_add = {1'b0, z} + addend;
    end
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Optional pipeline register: async active-high reset and clock enable, or a plain wire when EN_REG=0.
module pipe_reg #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          EN_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (EN_REG) begin : g_reg
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;

      always_comb begin
        data_d = data_q;
        if (ce) begin
          data_d = d;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign q = data_q;
    end else begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp_post_adder_stage.sv
// DSP48A1 post-adder: X/Z operand muxes, Z +/- (X + CIN), registered P/CARRYOUT with P feedback.
module dsp_post_adder_stage
  import dsp48a1_pkg::*;
#(
  parameter bit    OPMODEREG   = 1'b1,
  parameter bit    CARRYINREG  = 1'b1,
  parameter bit    PREG        = 1'b1,
  parameter bit    CARRYOUTREG = 1'b1,
  parameter string CARRYINSEL  = CARRYINSEL_OPMODE5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_opmode,
  input  logic         ce_carryin,
  input  logic         ce_p,
  input  logic [7:0]   opmode,
  input  logic [35:0]  m,
  input  logic [47:0]  dab,
  input  logic [47:0]  c,
  input  logic [47:0]  pcin,
  input  logic         carryin,
  output logic [47:0]  p,
  output logic [47:0]  pcout,
  output logic         carryout,
  output logic         carryoutf
);

  logic [OPMODE_W-1:0] opmode_q;
  logic                cyi_d;
  logic                cyi_q;
  logic [P_W-1:0]      x_mux;
  logic [P_W-1:0]      z_mux;
  logic [P_W:0]        sum;
  logic [P_W-1:0]      p_d;
  logic [P_W-1:0]      p_q;
  logic                co_d;
  logic                co_q;
  logic                unused_opmode;

  pipe_reg #(.WIDTH(OPMODE_W), .EN_REG(OPMODEREG)) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_opmode),
    .d   (opmode),
    .q   (opmode_q)
  );

  // Carry-in source is fixed at elaboration; the unselected source is left dangling.
  generate
    if (CARRYINSEL == CARRYINSEL_CARRYIN) begin : g_cyi_ext
      assign cyi_d         = carryin;
      assign unused_opmode = &{1'b0, opmode_q[4], opmode_q[OPM_CYI_BIT], opmode_q[6]};
    end else begin : g_cyi_opm
      assign cyi_d         = opmode_q[OPM_CYI_BIT];
      assign unused_opmode = &{1'b0, opmode_q[4], opmode_q[6], carryin};
    end
  endgenerate

  pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG)) u_cyi_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_carryin),
    .d   (cyi_d),
    .q   (cyi_q)
  );

  always_comb begin
    x_mux = '0;
    case (opmode_q[1:0])
      X_ZERO:  x_mux = '0;
      X_M:     x_mux = {(P_W-M_W)'(0), m};
      X_P:     x_mux = p_q;
      X_DAB:   x_mux = dab;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opmode_q[3:2])
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = pcin;
      Z_P:     z_mux = p_q;
      Z_C:     z_mux = c;
      default: z_mux = '0;
    endcase
  end

  always_comb begin
    sum  = post_add(opmode_q[OPM_SUB_BIT], z_mux, x_mux, cyi_q);
    p_d  = sum[P_W-1:0];
    co_d = sum[P_W];
  end

  pipe_reg #(.WIDTH(P_W), .EN_REG(PREG)) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_p),
    .d   (p_d),
    .q   (p_q)
  );

  pipe_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG)) u_co_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_p),
    .d   (co_d),
    .q   (co_q)
  );

  assign p         = p_q;
  assign pcout     = p_q;
  assign carryout  = co_q;
  assign carryoutf = co_q;

  // P feedback through an unregistered P is a combinational loop.
  generate
    if (!PREG) begin : g_no_feedback
      a_no_p_feedback: assert property (@(posedge clk) disable iff (rst)
        (opmode_q[1:0] != X_P) && (opmode_q[3:2] != Z_P));
    end
  endgenerate

endmodule

// File: tb/tb_dsp_post_adder_stage.sv
// Bench: fully registered instance (a) and opmode/CYI-bypassed CARRYIN instance (b), directed plus random.
module tb_dsp_post_adder_stage;

  logic        clk;
  logic        rst;
  logic        ce_opmode, ce_carryin, ce_p;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic        carryin;

  logic [47:0] pa, pcouta, pb, pcoutb;
  logic        coa, cofa, cob, cofb;

  int vectors;
  int miscompares;

  dsp_post_adder_stage u_dut_a (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(pa), .pcout(pcouta), .carryout(coa), .carryoutf(cofa)
  );

  dsp_post_adder_stage #(
    .OPMODEREG(1'b0), .CARRYINREG(1'b0), .CARRYINSEL("CARRYIN")
  ) u_dut_b (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(pb), .pcout(pcoutb), .carryout(cob), .carryoutf(cofb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Z +/- (X + cyi) on plain integers, result taken modulo 2^49.
  function automatic logic [48:0] ref_add(input logic [7:0] op, input logic cy,
                                          input logic [35:0] mm, input logic [47:0] d,
                                          input logic [47:0] cc, input logic [47:0] pc,
                                          input logic [47:0] pp);
    logic [48:0] xv, zv;
    case (op[1:0])
      2'd0: xv = 49'd0;
      2'd1: xv = 49'(mm);
      2'd2: xv = 49'(pp);
      default: xv = 49'(d);
    endcase
    case (op[3:2])
      2'd0: zv = 49'd0;
      2'd1: zv = 49'(pc);
      2'd2: zv = 49'(pp);
      default: zv = 49'(cc);
    endcase
    if (op[7]) ref_add = zv - (xv + 49'(cy));
    else       ref_add = zv + xv + 49'(cy);
  endfunction

  logic [7:0]  mo_q;
  logic        mc_q;
  logic [47:0] ma_p, mb_p;
  logic        ma_co, mb_co;

  // Cycle model: a sees opmode one edge late and opmode[5] two edges late; b sees inputs directly.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mo_q <= '0; mc_q <= 1'b0;
      ma_p <= '0; ma_co <= 1'b0; mb_p <= '0; mb_co <= 1'b0;
    end else begin
      if (ce_opmode)  mo_q <= opmode;
      if (ce_carryin) mc_q <= mo_q[5];
      if (ce_p) begin
        {ma_co, ma_p} <= ref_add(mo_q, mc_q, m, dab, c, pcin, ma_p);
        {mb_co, mb_p} <= ref_add(opmode, carryin, m, dab, c, pcin, mb_p);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    opmode = 8'h0D; m = 36'd5; c = 48'd7; dab = '0; pcin = '0; carryin = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({coa, cofa, pa, pcouta} !== '0) begin
      miscompares++; $display("FAIL reset_async_a: got p=%0h co=%0b exp 0", pa, coa);
    end
    vectors++;
    if ({cob, cofb, pb, pcoutb} !== '0) begin
      miscompares++; $display("FAIL reset_async_b: got p=%0h co=%0b exp 0", pb, cob);
    end
    #3 rst = 1'b0;
    step();
    vectors++;
    if (pb !== 48'd12) begin
      miscompares++; $display("FAIL reset_release_b: got %0d exp 12", pb);
    end
    vectors++;
    if (pa !== 48'd0) begin
      miscompares++; $display("FAIL reset_release_a_edge1: got %0d exp 0", pa);
    end
    step();
    vectors++;
    if (pa !== 48'd12) begin
      miscompares++; $display("FAIL reset_release_a_edge2: got %0d exp 12", pa);
    end
  endtask

  task automatic test_accumulate();
    opmode = 8'h09; m = 36'd3; carryin = 1'b0;
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (pa !== 48'(3 * k)) begin
        miscompares++; $display("FAIL accum_a[%0d]: got %0d exp %0d", k, pa, 3 * k);
      end
      vectors++;
      if (pb !== 48'(3 * (k + 1))) begin
        miscompares++; $display("FAIL accum_b[%0d]: got %0d exp %0d", k, pb, 3 * (k + 1));
      end
    end
    ce_p = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({pa, pb} !== {48'd12, 48'd15}) begin
        miscompares++; $display("FAIL accum_hold[%0d]: got a=%0d b=%0d exp 12 15", k, pa, pb);
      end
    end
    ce_p = 1'b1;
  endtask

  task automatic test_subtract();
    opmode = 8'h8F; c = 48'd10; dab = 48'd20; carryin = 1'b0;
    step(); step();
    vectors++;
    if ({coa, pa} !== {1'b1, 48'hFFFF_FFFF_FFF6}) begin
      miscompares++; $display("FAIL sub_borrow_a: got co=%0b p=%0h exp 1 fffffffffff6", coa, pa);
    end
    vectors++;
    if ({cob, pb} !== {1'b1, 48'hFFFF_FFFF_FFF6}) begin
      miscompares++; $display("FAIL sub_borrow_b: got co=%0b p=%0h exp 1 fffffffffff6", cob, pb);
    end
    c = 48'd20; dab = 48'd10;
    step();
    vectors++;
    if ({coa, pa, cob, pb} !== {1'b0, 48'd10, 1'b0, 48'd10}) begin
      miscompares++; $display("FAIL sub_pos: got a=%0d/%0b b=%0d/%0b exp 10/0", pa, coa, pb, cob);
    end
  endtask

  task automatic test_carryin_sel();
    carryin = 1'b1; opmode = 8'h0C; c = 48'hFFFF_FFFF_FFFF;
    step(); step();
    vectors++;
    if ({cob, pb} !== {1'b1, 48'd0}) begin
      miscompares++; $display("FAIL cin_extern_b: got co=%0b p=%0h exp 1 0", cob, pb);
    end
    vectors++;
    if ({coa, pa} !== {1'b0, 48'hFFFF_FFFF_FFFF}) begin
      miscompares++; $display("FAIL cin_opmode5_lo_a: got co=%0b p=%0h exp 0 ffffffffffff", coa, pa);
    end
    opmode = 8'h2C;
    step(); step();
    vectors++;
    if ({coa, pa} !== {1'b0, 48'hFFFF_FFFF_FFFF}) begin
      miscompares++; $display("FAIL cin_opmode5_lat_a: got co=%0b p=%0h exp 0 ffffffffffff", coa, pa);
    end
    step();
    vectors++;
    if ({coa, pa} !== {1'b1, 48'd0}) begin
      miscompares++; $display("FAIL cin_opmode5_hi_a: got co=%0b p=%0h exp 1 0", coa, pa);
    end
  endtask

  task automatic test_cascade();
    opmode = 8'h04; pcin = 48'h1234_5678_9ABC; carryin = 1'b0;
    step(); step(); step();
    vectors++;
    if ({pa, pcouta, pb, pcoutb} !== {4{48'h1234_5678_9ABC}}) begin
      miscompares++; $display("FAIL cascade: got a=%0h/%0h b=%0h/%0h exp 123456789abc", pa, pcouta, pb, pcoutb);
    end
    opmode = 8'h00;
    step(); step();
    vectors++;
    if ({pa, pb, coa, cob} !== '0) begin
      miscompares++; $display("FAIL zero: got a=%0h b=%0h exp 0", pa, pb);
    end
  endtask

  task automatic test_bypass();
    opmode = 8'h01; m = 36'd5; dab = 48'h99; carryin = 1'b0;
    step(); step(); step();
    opmode = 8'h03;
    step();
    vectors++;
    if ({pb, pa} !== {48'h99, 48'd5}) begin
      miscompares++; $display("FAIL bypass_edge1: got b=%0h a=%0h exp 99 5", pb, pa);
    end
    step();
    vectors++;
    if (pa !== 48'h99) begin
      miscompares++; $display("FAIL registered_edge2: got %0h exp 99", pa);
    end
  endtask

  task automatic test_ce_hold();
    ce_p = 1'b0; opmode = 8'h0C; c = 48'd77;
    step(); step(); step();
    vectors++;
    if ({pa, pb} !== {48'h99, 48'h99}) begin
      miscompares++; $display("FAIL ce_p_hold: got a=%0h b=%0h exp 99 99", pa, pb);
    end
    ce_p = 1'b1;
    step();
    vectors++;
    if ({pa, pb} !== {48'd77, 48'd77}) begin
      miscompares++; $display("FAIL ce_p_resume: got a=%0d b=%0d exp 77 77", pa, pb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      opmode     = 8'($urandom);
      m          = 36'({$urandom, $urandom});
      dab        = 48'({$urandom, $urandom});
      c          = 48'({$urandom, $urandom});
      pcin       = 48'({$urandom, $urandom});
      carryin    = 1'($urandom);
      ce_opmode  = ($urandom_range(0, 3) != 0);
      ce_carryin = ($urandom_range(0, 3) != 0);
      ce_p       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
      step();
      vectors++;
      if ({coa, cofa, pa, pcouta} !== {ma_co, ma_co, ma_p, ma_p}) begin
        miscompares++;
        $display("FAIL rand_a[%0d]: got p=%0h co=%0b exp p=%0h co=%0b", i, pa, coa, ma_p, ma_co);
      end
      vectors++;
      if ({cob, cofb, pb, pcoutb} !== {mb_co, mb_co, mb_p, mb_p}) begin
        miscompares++;
        $display("FAIL rand_b[%0d]: got p=%0h co=%0b exp p=%0h co=%0b", i, pb, cob, mb_p, mb_co);
      end
    end
    ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
    opmode = '0; m = '0; dab = '0; c = '0; pcin = '0; carryin = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({pa, coa, pb, cob} !== '0) begin
      miscompares++; $display("FAIL reset_initial: got a=%0h b=%0h exp 0", pa, pb);
    end
    #10 rst = 1'b0;
    test_reset();
    test_accumulate();
    test_subtract();
    test_carryin_sel();
    test_cascade();
    test_bypass();
    test_ce_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_stage.md
# dsp_post_adder_stage

Final arithmetic stage of the DSP48A1 slice model. It takes the multiplier product M, the concatenated D:A:B word, C and the cascade input PCIN. It selects X and Z operands under OPMODE control and performs Z ± (X + CIN) in a 48-bit post-adder. The result and carry are registered into P and CARRYOUT, and P is fed back so the stage can act as an accumulator. It sits directly downstream of the operand pipeline registers and multiplier, and drives the slice outputs and the PCOUT/CARRYOUT cascade.

## Interface
- OPMODEREG, 1: register opmode (1) or pass through combinationally (0)
- CARRYINREG, 1: register selected carry-in (CYI) before the post-adder
- PREG, 1: register post-adder result into P
- CARRYOUTREG, 1: register post-adder carry into CARRYOUT
- CARRYINSEL, "OPMODE5": carry-in source, "OPMODE5" or "CARRYIN"
- clk  in  1  clock, all registers rising-edge
- rst  in  1  reset, asynchronous, active-high; clears every register in the block
- ce_opmode  in  1  clock enable, opmode register
- ce_carryin  in  1  clock enable, CYI register
- ce_p  in  1  clock enable, P and CARRYOUT registers
- opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry-in value, [7] subtract; [4],[6] ignored
- m  in  36  multiplier product, zero-extended to 48
- dab  in  48  {D[11:0], A[17:0], B[17:0]}
- c  in  48  C operand (already registered upstream)
- pcin  in  48  cascade input from previous slice
- carryin  in  1  external carry-in
- p  out  48  result
- pcout  out  48  copy of p
- carryout  out  1  post-adder carry/borrow
- carryoutf  out  1  copy of carryout

## Operation
- X mux, selected by opmode_q[1:0]:
  - 0 → 48'd0
  - 1 → {12'd0, m}
  - 2 → p (current output, feedback)
  - 3 → dab
- Z mux, selected by opmode_q[3:2]:
  - 0 → 48'd0
  - 1 → pcin
  - 2 → p
  - 3 → c
- cyi_d = opmode_q[5] when CARRYINSEL="OPMODE5", else carryin. cyi is the registered (CARRYINREG=1) or direct version.
- Post-adder uses a 49-bit result {co, r}:
  - opmode_q[7]=0 → Z + X + cyi
  - opmode_q[7]=1 → Z − (X + cyi)
  - Computed on zero-extended 49-bit operands; co is bit 48 (borrow on subtract).
- p = PREG ? p_q : r, and carryout = CARRYOUTREG ? co_q : co.
- Feedback with PREG=0 creates a combinational loop. It is unsupported: elaboration error or assertion when PREG=0 and X/Z=2 is selected.
- All arithmetic wraps modulo 2^48; there is no saturation or overflow flag.

## Timing
- Reset: p, pcout, carryout, carryoutf, opmode_q and cyi are all 0, immediately on rst assertion regardless of clk.
- rst deasserting mid-accumulation restarts from P=0. Registers hold 0 until the first enabled edge after release.
- Latency from operand change to p with all REG=1:
  - m, dab, c, pcin → 1 cycle
  - opmode, carryin → 2 cycles (opmode/CYI register, then P)
- With OPMODEREG=0 and CARRYINREG=0, opmode/carryin latency is 1 cycle.
- Each register has its own enable. When a register's CE is low it holds its value, and the other registers still update.
- ce_p low with ce_opmode high: the new opmode is captured, but P holds until ce_p rises.
- Accumulate (X=M, Z=P): P(n+1) = P(n) + M + cyi on every ce_p cycle.
- rst has priority over every CE.

## Structure
- Shared package dsp48a1_pkg, which holds:
  - widths P_W=48, M_W=36, OPMODE_W=8
  - X-select constants X_ZERO, X_M, X_P, X_DAB
  - Z-select constants Z_ZERO, Z_PCIN, Z_P, Z_C
  - the CARRYINSEL string constants
- One sub-module, pipe_reg (WIDTH, EN_REG params; async active-high reset, clock enable, bypass when EN_REG=0). It is instantiated for opmode, CYI, P and CARRYOUT.

## Test plan
- Reset: drive opmode=8'h0D, m=5, c=7, then assert rst mid-cycle → p=0 and carryout=0 immediately. After release and 1 edge, p = 7+5 = 12.
- Accumulate: opmode=8'h09 (X=M, Z=P), m=3, ce_p=1 for 4 edges from P=0 → p = 3, 6, 9, 12. Drop ce_p for 2 cycles → p holds at 12.
- Subtract with borrow: opmode=8'h8F (X=DAB, Z=C), c=10, dab=20, cyi=0 → p = 48'hFFFF_FFFF_FFF6 and carryout=1. With c=20 and dab=10 → p=10, carryout=0.
- Carry-in select:
  - CARRYINSEL="CARRYIN", carryin=1, opmode=8'h0C (Z=C), c=48'hFFFF_FFFF_FFFF → 2 cycles later p=0, carryout=1.
  - Same stimulus with CARRYINSEL="OPMODE5" and opmode[5]=0 → p=48'hFFFF_FFFF_FFFF, carryout=0.
- Cascade/zero: opmode=8'h04 (X=0, Z=PCIN), pcin=48'h1234_5678_9ABC → p and pcout both equal pcin after 1 cycle. opmode=8'h00 → p=0.
- Pipeline bypass: OPMODEREG=CARRYINREG=0, switch opmode from 8'h01 to 8'h03 at an edge → p reflects dab at the very next edge. With OPMODEREG=1, it reflects dab one edge later.
